cpu_step_ctrl: RTL and testbench
================================

// Module: cpu_step_ctrl
// PURPOSE
//   Sits directly downstream of the free-running clock generator and turns its clk into a gated
//   CPU tick. Produces a one-cycle clock-enable (cpu_en) that the CPU datapath qualifies every
//   state update with. Supports free-run, halt, single-step and a bounded-run cycle limit.
//   Counts retired ticks for the benches.
// PARAMETERS
//   DIV         default 1   cpu_en rate in RUN: one pulse every DIV clk cycles (DIV >= 1)
//   CNT_W       default 32  width of cycle_count
//   MAX_CYCLES  default 0   tick limit; 0 = unlimited, >0 = enter DONE after that many ticks
// PORTS
//   clk          in   1      free-running clock from the clock generator
//   reset_n      in   1      reset, asynchronous, active-low
//   run          in   1      level; 1 requests free-run
//   halt         in   1      level; highest priority, forces/holds HALTED
//   step         in   1      level; each rising edge requests exactly one tick
//   cpu_en       out  1      one-cycle CPU tick enable
//   cycle_count  out  CNT_W  number of cpu_en cycles since reset
//   running      out  1      1 while in RUN
//   done         out  1      1 while in DONE
// BEHAVIOUR
//   Reset (reset_n=0, async, no clk needed): state=HALTED, prescaler=0, step_q=0,
//     cycle_count=0. cpu_en, running and done are all 0.
//   Clock domain: one clock (clk), rising edge only.
//   States: HALTED, RUN, STEP, DONE. Transitions are evaluated at each clk rising edge.
//   Input priority: halt > run > step.
//   Step edge detect: step_rise = step & ~step_q, where step_q is step registered every cycle.
//   HALTED:
//     halt=1 -> HALTED.
//     run=1 -> RUN; the prescaler is cleared.
//     step_rise -> STEP.
//     Otherwise HALTED.
//   RUN:
//     halt=1 or run=0 -> HALTED; the prescaler is cleared.
//     Otherwise the prescaler counts 0..DIV-1 and wraps to 0.
//   STEP: lasts exactly one cycle, then HALTED unconditionally. halt cannot abort a STEP
//     already entered. A held step gives one tick only; a new tick needs step to fall and rise.
//   DONE: absorbing. All inputs are ignored; only reset exits DONE.
//   cpu_en = (state==RUN && prescaler==DIV-1) || state==STEP.
//     Decoded from registers only; there is no combinational path from inputs to outputs.
//   Tick timing in RUN: the first cycle in RUN is cycle 1, and cpu_en is high in cycles DIV,
//     2*DIV, ... With DIV=1, cpu_en stays high for every cycle spent in RUN.
//   running = (state==RUN); done = (state==DONE).
//   cycle_count increments by 1 at every rising edge where cpu_en=1.
//     MAX_CYCLES=0: cycle_count wraps 2^CNT_W-1 -> 0 silently.
//     MAX_CYCLES>0: the edge that brings cycle_count to MAX_CYCLES also moves the state to
//     DONE, overriding halt, run and step. cycle_count then holds at MAX_CYCLES.
//   Reset mid-RUN or mid-STEP: outputs drop to their reset values immediately. No partial tick
//     is carried over.
//   Prescaler width: $clog2(DIV), minimum 1 bit. For DIV=1 the compare prescaler==0 is always true.
// TESTING
//   1 Reset: DIV=1, run=1 for 5 ticks, then reset_n=0 between edges -> cpu_en=0,
//     cycle_count=0, running=0 before the next clk edge.
//   2 Divide: DIV=4, run=1 held for 16 cycles -> cpu_en high only in cycles 4, 8, 12 and 16
//     after RUN entry; cycle_count=4; running=1 throughout.
//   3 Single-step: HALTED, step held high for 5 cycles -> exactly 1 cpu_en pulse, cycle_count=1.
//     Release step, raise it again -> cycle_count=2.
//   4 Priority: run=1 and halt=1 together -> stays HALTED, no cpu_en for 10 cycles.
//     Drop halt -> RUN on the next edge.
//   5 Limit: MAX_CYCLES=3, DIV=1, run=1 -> exactly 3 cpu_en cycles, cycle_count=3, done=1.
//     Further run/step/halt activity -> no cpu_en, cycle_count stays at 3.
//   6 Wrap: CNT_W=4, MAX_CYCLES=0, DIV=1, run for 17 ticks -> cycle_count goes 15 -> 0 -> 1.
//     No DONE state and no stall occur.

Source files
------------

// File: rtl/cpu_step_ctrl.sv
// cpu_step_ctrl: gates the free-running clk into a one-cycle CPU tick enable.
// Supports free-run (optionally divided), halt, single-step and a bounded run
// that parks in DONE once MAX_CYCLES ticks have been retired.
//
// state    | meaning
// ---------+------------------------------------------------------------
// S_HALTED | idle, no ticks; waits for run or a rising edge on step
// S_RUN    | free-run, one tick every DIV cycles
// S_STEP   | single tick, lasts exactly one cycle, then back to S_HALTED
// S_DONE   | tick limit reached; absorbing until reset
module cpu_step_ctrl #(
  parameter int DIV        = 1,
  parameter int CNT_W      = 32,
  parameter int MAX_CYCLES = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             run,
  input  logic             halt,
  input  logic             step,
  output logic             cpu_en,
  output logic [CNT_W-1:0] cycle_count,
  output logic             running,
  output logic             done
);

  localparam int               PW      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0]    PRE_TOP = PW'(DIV - 1);
  localparam logic [CNT_W-1:0] LIMIT   = CNT_W'(MAX_CYCLES);
  localparam bit               LIMITED = (MAX_CYCLES > 0);

  typedef enum logic [1:0] {S_HALTED, S_RUN, S_STEP, S_DONE} state_t;

  state_t           state;
  logic [PW-1:0]    prescaler;
  logic             step_q;
  logic             step_rise;
  logic [CNT_W-1:0] count_inc;
  logic             limit_hit;

  assign step_rise = step & ~step_q;
  assign count_inc = cycle_count + CNT_W'(1);
  // The tick that lands cycle_count on the limit wins over every input.
  assign limit_hit = LIMITED && cpu_en && (count_inc == LIMIT);

  // Outputs are decoded purely from registers; no input reaches them combinationally.
  assign cpu_en  = ((state == S_RUN) && (prescaler == PRE_TOP)) || (state == S_STEP);
  assign running = (state == S_RUN);
  assign done    = (state == S_DONE);

  // Step edge detector: remembers last cycle's step level.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) step_q <= 1'b0;
    else          step_q <= step;
  end

  // Retired-tick counter; freezes naturally in DONE because cpu_en is low there.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)    cycle_count <= '0;
    else if (cpu_en) cycle_count <= count_inc;
  end

  // Sequencing FSM with the RUN-mode prescaler.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_HALTED;
      prescaler <= '0;
    end else if (limit_hit) begin
      state     <= S_DONE;
      prescaler <= '0;
    end else begin
      case (state)
        S_HALTED: begin
          if (halt) begin
            state <= S_HALTED;
          end else if (run) begin
            state     <= S_RUN;
            prescaler <= '0;
          end else if (step_rise) begin
            state <= S_STEP;
          end
        end
        S_RUN: begin
          if (halt || !run) begin
            state     <= S_HALTED;
            prescaler <= '0;
          end else if (prescaler == PRE_TOP) begin
            prescaler <= '0;
          end else begin
            prescaler <= prescaler + PW'(1);
          end
        end
        S_STEP:  state <= S_HALTED;
        S_DONE:  state <= S_DONE;
        default: state <= S_HALTED;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_step_ctrl.sv
// Bench for cpu_step_ctrl: three parameterisations share one stimulus stream
// (divided run, 4-bit wrapping counter, 3-tick limit) and are compared every
// cycle against a mode/cycle-index reference model.
module tb_cpu_step_ctrl;
  localparam int N = 3;
  localparam int M_HALT = 0, M_RUN = 1, M_STEP = 2, M_DONE = 3;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic run = 1'b0, halt = 1'b0, step = 1'b0;
  logic [N-1:0] en, rn, dn;
  logic [31:0] cnt_a;
  logic [3:0]  cnt_b;
  logic [7:0]  cnt_c;

  int divs [N];
  int ws   [N];
  int maxs [N];
  int     m_mode [N];
  int     m_runc [N];
  longint m_cnt  [N];
  bit     m_stepq;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cpu_step_ctrl #(.DIV(4), .CNT_W(32), .MAX_CYCLES(0)) dut_a (
    .clk(clk), .reset_n(reset_n), .run(run), .halt(halt), .step(step),
    .cpu_en(en[0]), .cycle_count(cnt_a), .running(rn[0]), .done(dn[0]));
  cpu_step_ctrl #(.DIV(1), .CNT_W(4), .MAX_CYCLES(0)) dut_b (
    .clk(clk), .reset_n(reset_n), .run(run), .halt(halt), .step(step),
    .cpu_en(en[1]), .cycle_count(cnt_b), .running(rn[1]), .done(dn[1]));
  cpu_step_ctrl #(.DIV(1), .CNT_W(8), .MAX_CYCLES(3)) dut_c (
    .clk(clk), .reset_n(reset_n), .run(run), .halt(halt), .step(step),
    .cpu_en(en[2]), .cycle_count(cnt_c), .running(rn[2]), .done(dn[2]));

  function automatic bit m_en(int i);
    return ((m_mode[i] == M_RUN) && (m_runc[i] % divs[i] == 0)) || (m_mode[i] == M_STEP);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_mode[i] = M_HALT;
      m_runc[i] = 0;
      m_cnt[i]  = 0;
    end
    m_stepq = 1'b0;
  endtask

  // One rising edge of the reference: uses the inputs held across the edge.
  task automatic model_edge();
    bit rise;
    rise = step && !m_stepq;
    for (int i = 0; i < N; i++) begin
      bit     e;
      longint mask;
      longint nc;
      e    = m_en(i);
      mask = (longint'(1) << ws[i]) - 1;
      nc   = e ? ((m_cnt[i] + 1) & mask) : m_cnt[i];
      if (m_mode[i] != M_DONE) begin
        if (maxs[i] > 0 && e && nc == maxs[i]) begin
          m_mode[i] = M_DONE;
        end else begin
          case (m_mode[i])
            M_HALT: begin
              if (halt) m_mode[i] = M_HALT;
              else if (run) begin m_mode[i] = M_RUN; m_runc[i] = 1; end
              else if (rise) m_mode[i] = M_STEP;
            end
            M_RUN: begin
              if (halt || !run) m_mode[i] = M_HALT;
              else m_runc[i] = m_runc[i] + 1;
            end
            default: m_mode[i] = M_HALT;
          endcase
        end
      end
      m_cnt[i] = nc;
    end
    m_stepq = step;
  endtask

  task automatic chk(string tag, int i, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s dut%0d observed=%0d expected=%0d", tag, i, obs, exp);
    end
  endtask

  task automatic check_all(string ph);
    for (int i = 0; i < N; i++) begin
      logic [31:0] c;
      c = (i == 0) ? cnt_a : (i == 1) ? 32'(cnt_b) : 32'(cnt_c);
      chk({ph, "_cpu_en"},  i, 32'(en[i]), 32'(m_en(i)));
      chk({ph, "_count"},   i, c, 32'(m_cnt[i]));
      chk({ph, "_running"}, i, 32'(rn[i]), 32'(m_mode[i] == M_RUN));
      chk({ph, "_done"},    i, 32'(dn[i]), 32'(m_mode[i] == M_DONE));
    end
  endtask

  task automatic tick(string ph);
    @(posedge clk);
    model_edge();
    #1;
    check_all(ph);
  endtask

  // Asynchronous reset applied between edges; outputs must clear without a clock.
  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    model_reset();
    check_all("async_reset");
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    divs = '{4, 1, 1};
    ws   = '{32, 4, 8};
    maxs = '{0, 0, 3};
    model_reset();
    #2;
    check_all("por");
    #1;
    reset_n = 1'b1;

    // Free run: divided ticks, 4-bit wrap, limit to DONE.
    run = 1'b1;
    repeat (20) tick("run");
    do_reset();

    // Halt dominates run, then RUN starts on the edge after halt drops.
    run = 1'b1; halt = 1'b1;
    repeat (10) tick("prio");
    halt = 1'b0;
    tick("prio_release");
    run = 1'b0;
    tick("prio_stop");

    // Held step gives one tick; re-raise gives another.
    step = 1'b1;
    repeat (5) tick("step_hold");
    step = 1'b0;
    repeat (2) tick("step_low");
    step = 1'b1;
    repeat (2) tick("step_again");
    step = 1'b0;
    tick("step_end");

    // Activity after DONE must be ignored.
    run = 1'b1; step = 1'b1; halt = 1'b1;
    repeat (3) tick("post_done");
    halt = 1'b0; step = 1'b0;
    repeat (3) tick("post_done");

    // Randomized traffic with occasional resets.
    repeat (400) begin
      run  = ($urandom_range(0, 3) != 0);
      halt = ($urandom_range(0, 7) == 0);
      step = $urandom_range(0, 1) == 1;
      if ($urandom_range(0, 63) == 0) do_reset();
      tick("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
